traffic_timer: RTL and testbench
================================

TRAFFIC_TIMER -- requirements
Module: traffic_timer

Interface
REQ-001 Parameter CLK_PER_SEC, default 10, SHALL set the clk cycles per one-second countdown tick (legal range 2..1023).
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 Reset  input  1  SHALL be the reset: synchronous, active-high.
REQ-004 start_timer  input  1  SHALL be a one-cycle request from the light FSM to begin timing an interval.
REQ-005 interval_in  input  2  SHALL be the interval code from the FSM (00 base, 01 extended, 10 yellow, 11 reserved), sampled with start_timer.
REQ-006 interval  output  2  SHALL be the registered interval code driven to the time-parameter block's interval input.
REQ-007 value  input  4  SHALL be the time in seconds returned by the time-parameter block for the driven interval.
REQ-008 busy  output  1  SHALL be high in every state except IDLE.
REQ-009 expired  output  1  SHALL be a one-cycle pulse marking the end of the timed interval.
REQ-010 remaining  output  4  SHALL be the seconds left in the current countdown.

Function
REQ-011 FSM states SHALL be IDLE, REQ, LOAD, RUN and DONE, held in one registered state variable.
REQ-012 IDLE + start_timer -> REQ; interval <= interval_in on the same edge.
REQ-013 REQ SHALL last exactly one cycle with interval held stable, then go to LOAD.
REQ-014 LOAD SHALL last one cycle; on its closing edge remaining <= value and the prescaler <= 0.
REQ-015 LOAD exit: value != 0 -> RUN; value == 0 -> DONE directly, with no tick consumed.
REQ-016 Prescaler in RUN SHALL count 0..CLK_PER_SEC-1; tick = (prescaler == CLK_PER_SEC-1); on tick the prescaler wraps to 0.
REQ-017 On a tick in RUN, remaining SHALL decrement by 1; a tick with remaining == 1 SHALL set remaining to 0 and go to DONE.
REQ-018 DONE SHALL last one cycle with expired = 1, then go to IDLE; expired SHALL be 0 in all other states.
REQ-019 Expiry latency SHALL be 2 + value*CLK_PER_SEC edges from the start-sampling edge to the edge that enters DONE.
REQ-020 start_timer in REQ, LOAD or RUN SHALL restart the sequence: interval <= interval_in, state -> REQ, prescaler cleared, remaining unchanged until the next LOAD.
REQ-021 start_timer in DONE SHALL still emit the expired pulse that cycle and SHALL go to REQ instead of IDLE (back-to-back intervals).
REQ-022 interval_in == 11 SHALL be forwarded unchanged; the time-parameter block defines the returned value.
REQ-023 interval SHALL change only on an accepted start_timer; it holds its value in IDLE.
REQ-024 The prescaler width SHALL be $clog2(CLK_PER_SEC); no arithmetic overflow in remaining (decrement never below 0).

Reset
REQ-025 Reset high at a clock edge SHALL force state IDLE, interval 00, remaining 0, prescaler 0, busy 0 and expired 0, overriding start_timer.
REQ-026 Reset mid-RUN or in DONE SHALL abort with no expired pulse; the first start_timer after Reset falls is honoured normally.

Structure
REQ-027 State encodings and interval codes (BASE/EXT/YEL) SHALL live in a shared traffic-light package also used by the FSM and the time-parameter block.
REQ-028 The prescaler SHALL be a sub-module named tick_gen (inputs clk, Reset, clear, enable; output tick); the FSM and countdown stay in traffic_timer.

Verification (CLK_PER_SEC = 4)
REQ-029 Reset for 3 cycles, then release -> busy 0, expired 0, interval 00, remaining 0.
REQ-030 start_timer with interval_in 01, value model 6 -> interval 01 after edge 0, remaining 6 after edge 2, then 5,4,...,1 every 4 cycles, expired one cycle after edge 26, busy 0 after edge 27.
REQ-031 start_timer with interval_in 10, value 0 -> expired high after edge 2 for exactly one cycle, no RUN cycles.
REQ-032 Reset asserted at edge 12 of a value-6 run -> IDLE next cycle, no expired pulse, remaining 0.
REQ-033 start_timer in the DONE cycle with interval_in 00, value 3 -> expired pulse still seen, busy stays 1, second expiry 2+12 edges later.
REQ-034 start_timer re-asserted at edge 10 of a value-6 run with value 2 -> restart, expired 2+8 edges after edge 10, no earlier pulse.

Source files
------------

// File: rtl/traffic_timer_pkg.sv
// Shared traffic-light definitions: timer FSM states and interval codes used by
// the light FSM, the interval timer and the time-parameter block.
package traffic_timer_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        LOAD = 3'd2,
        RUN  = 3'd3,
        DONE = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        IV_BASE = 2'b00,
        IV_EXT  = 2'b01,
        IV_YEL  = 2'b10,
        IV_RSVD = 2'b11
    } interval_t;

endpackage

// File: rtl/traffic_timer_tick_gen.sv
// One-second prescaler: counts 0..CLK_PER_SEC-1 while enabled and flags the
// last count as a tick, wrapping to zero on it.
module tick_gen #(
    parameter int CLK_PER_SEC = 10
) (
    input  logic clk,
    input  logic Reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int PW = $clog2(CLK_PER_SEC);
    localparam logic [PW-1:0] LAST = PW'(CLK_PER_SEC - 1);

    logic [PW-1:0] cnt;

    assign tick = enable && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (Reset || clear)
            cnt <= '0;
        else if (enable)
            cnt <= tick ? '0 : cnt + PW'(1);
    end

endmodule

// File: rtl/traffic_timer.sv
// Interval timer for the traffic-light controller: requests a duration from the
// time-parameter block, counts it down in seconds and pulses expired at the end.
module traffic_timer
    import traffic_timer_pkg::*;
#(
    parameter int CLK_PER_SEC = 10
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic       start_timer,
    input  logic [1:0] interval_in,
    output logic [1:0] interval,
    input  logic [3:0] value,
    output logic       busy,
    output logic       expired,
    output logic [3:0] remaining
);

    state_t state, state_nx;
    logic   tick;
    logic   run_en;
    logic   pre_clear;

    assign run_en    = (state == RUN);
    // Restarts and every non-RUN state keep the prescaler parked at zero.
    assign pre_clear = start_timer || !run_en;

    tick_gen #(.CLK_PER_SEC(CLK_PER_SEC)) u_tick_gen (
        .clk    (clk),
        .Reset  (Reset),
        .clear  (pre_clear),
        .enable (run_en),
        .tick   (tick)
    );

    always_ff @(posedge clk) begin
        if (Reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        busy     = (state != IDLE);
        expired  = (state == DONE);
        case (state)
            IDLE: state_nx = IDLE;
            REQ:  state_nx = LOAD;
            LOAD: state_nx = (value != 4'd0) ? RUN : DONE;
            RUN:  if (tick && remaining == 4'd1) state_nx = DONE;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        // A start request restarts the sequence from any state, DONE included.
        if (start_timer)
            state_nx = REQ;
    end

    always_ff @(posedge clk) begin
        if (Reset)
            interval <= IV_BASE;
        else if (start_timer)
            interval <= interval_in;
    end

    always_ff @(posedge clk) begin
        if (Reset)
            remaining <= 4'd0;
        else if (!start_timer) begin
            if (state == LOAD)
                remaining <= value;
            else if (run_en && tick && remaining != 4'd0)
                remaining <= remaining - 4'd1;
        end
    end

endmodule

// File: tb/tb_traffic_timer.sv
// Bench for traffic_timer: directed vectors, multi-cycle corner sequences and
// random start/reset traffic against a per-interval arithmetic timing model.
module tb_traffic_timer;

    localparam int CPS = 4;

    logic       clk;
    logic       Reset;
    logic       start_timer;
    logic [1:0] interval_in;
    logic [1:0] interval;
    logic [3:0] value;
    logic       busy;
    logic       expired;
    logic [3:0] remaining;

    logic [3:0] val_tab [4];

    assign value = val_tab[interval];

    traffic_timer #(.CLK_PER_SEC(CPS)) dut (
        .clk         (clk),
        .Reset       (Reset),
        .start_timer (start_timer),
        .interval_in (interval_in),
        .interval    (interval),
        .value       (value),
        .busy        (busy),
        .expired     (expired),
        .remaining   (remaining)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [1:0] code;
        logic [3:0] val;
        int         lat;
    } vec_t;

    vec_t vecs [5];

    // Model: an accepted start at edge t0 gives busy through t0+L, expired at
    // t0+L, and remaining = val - (p-2)/CPS for 2 <= p < L, with L = 2+val*CPS.
    int         e      = 0;
    bit         m_act  = 0;
    int         m_t0   = 0;
    int         m_val  = 0;
    int         m_rem  = 0;
    int         m_hold = 0;
    logic [1:0] m_int  = 2'b00;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, e);
        end
    endtask

    task automatic step(input bit s, input logic [1:0] c, input bit r);
        int p, len, exp_b, exp_x;
        Reset       = r;
        start_timer = s;
        interval_in = c;
        @(posedge clk);
        e++;
        if (r) begin
            m_act = 0;
            m_int = 2'b00;
            m_rem = 0;
        end else if (s) begin
            m_hold = m_rem;
            m_act  = 1;
            m_t0   = e;
            m_int  = c;
            m_val  = int'(val_tab[c]);
        end
        exp_b = 0;
        exp_x = 0;
        if (m_act) begin
            p   = e - m_t0;
            len = 2 + m_val * CPS;
            if (p > len) begin
                m_act = 0;
                m_rem = 0;
            end else begin
                exp_b = 1;
                exp_x = (p == len) ? 1 : 0;
                if (p < 2)        m_rem = m_hold;
                else if (p < len) m_rem = m_val - (p - 2) / CPS;
                else              m_rem = 0;
            end
        end
        #1;
        chk("busy", int'(busy), exp_b);
        chk("expired", int'(expired), exp_x);
        chk("remaining", int'(remaining), m_rem);
        chk("interval", int'(interval), int'(m_int));
        Reset       = 1'b0;
        start_timer = 1'b0;
    endtask

    task automatic wait_exp(input string name, input int t0, input int exp_lat);
        int n;
        n = 0;
        while (!expired && n < 200) begin
            step(1'b0, 2'b00, 1'b0);
            n++;
        end
        chk(name, expired ? (e - t0) : -1, exp_lat);
    endtask

    int pulses;
    int t0;

    initial begin
        Reset       = 1'b1;
        start_timer = 1'b0;
        interval_in = 2'b00;
        for (int i = 0; i < 4; i++) val_tab[i] = 4'd0;

        vecs[0] = '{code: 2'b01, val: 4'd6,  lat: 26};
        vecs[1] = '{code: 2'b10, val: 4'd0,  lat: 2};
        vecs[2] = '{code: 2'b00, val: 4'd3,  lat: 14};
        vecs[3] = '{code: 2'b11, val: 4'd15, lat: 62};
        vecs[4] = '{code: 2'b00, val: 4'd1,  lat: 6};

        // Reset for three cycles, then release
        for (int i = 0; i < 3; i++) step(1'b0, 2'b00, 1'b1);
        step(1'b0, 2'b00, 1'b0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_expired", int'(expired), 0);
        chk("rst_interval", int'(interval), 0);
        chk("rst_remaining", int'(remaining), 0);

        foreach (vecs[i]) begin
            val_tab[vecs[i].code] = vecs[i].val;
            step(1'b1, vecs[i].code, 1'b0);
            t0 = e;
            wait_exp("vec_latency", t0, vecs[i].lat);
            step(1'b0, 2'b00, 1'b0);
            chk("vec_idle_after", int'(busy), 0);
            step(1'b0, 2'b00, 1'b0);
        end

        // Reset at edge 12 of a value-6 run aborts without a pulse
        val_tab[1] = 4'd6;
        step(1'b1, 2'b01, 1'b0);
        for (int i = 1; i < 12; i++) step(1'b0, 2'b00, 1'b0);
        step(1'b0, 2'b00, 1'b1);
        chk("abort_busy", int'(busy), 0);
        chk("abort_remaining", int'(remaining), 0);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 2'b00, 1'b0);
            if (expired) pulses++;
        end
        chk("abort_no_pulse", pulses, 0);

        // Start during DONE: pulse still seen, busy held, second run follows
        val_tab[1] = 4'd6;
        val_tab[0] = 4'd3;
        step(1'b1, 2'b01, 1'b0);
        t0 = e;
        wait_exp("b2b_first", t0, 26);
        step(1'b1, 2'b00, 1'b0);
        t0 = e;
        chk("b2b_busy", int'(busy), 1);
        wait_exp("b2b_second", t0, 14);
        step(1'b0, 2'b00, 1'b0);

        // Restart at edge 10 of a value-6 run with a value-2 interval
        val_tab[1] = 4'd6;
        val_tab[2] = 4'd2;
        step(1'b1, 2'b01, 1'b0);
        pulses = 0;
        for (int i = 1; i < 10; i++) begin
            step(1'b0, 2'b00, 1'b0);
            if (expired) pulses++;
        end
        step(1'b1, 2'b10, 1'b0);
        t0 = e;
        wait_exp("restart_latency", t0, 10);
        chk("restart_no_early", pulses, 0);
        step(1'b0, 2'b00, 1'b0);

        // Random start/reset traffic
        for (int seg = 0; seg < 4; seg++) begin
            step(1'b0, 2'b00, 1'b1);
            for (int i = 0; i < 4; i++) val_tab[i] = 4'($urandom_range(0, 7));
            for (int i = 0; i < 600; i++) begin
                step(($urandom_range(0, 29) == 0),
                     2'($urandom_range(0, 3)),
                     ($urandom_range(0, 299) == 0));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
